// File: rtl/d_branch_ctrl.sv
// d_branch_ctrl
//   Decode-stage branch hazard controller. Keeps a 32-entry scoreboard of
//   two-bit countdowns that say how many cycles remain before each register
//   result can be forwarded into the D-stage comparator. A compare-branch
//   in D is held until both of its sources are forwardable. A branch that
//   leaves D is reported one cycle later on the E_br_* outputs.
//
// Parameters
//   MAX_STALL    longest run of consecutive stall cycles on one branch
//                before err_timeout is raised
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   D_valid      an instruction occupies D
//   D_is_branch  the D instruction is a compare-branch
//   D_CMPop      3'd0 beq (rs, rt), 3'd1 bltzal (rs only), others not branches
//   D_rs, D_rt   comparator source registers
//   D_cmp_sig    comparator result for the current D operands
//   D_wr, D_rd   the D instruction writes D_rd
//   D_lat        cycles until that result is forwardable (1 ALU, 2 load, 3 mul)
//   D_stall      hold F and D this cycle (combinational)
//   E_br_valid   a branch left D last cycle
//   E_br_taken   that branch is taken
//   err_timeout  sticky stall-timeout flag
//   stall_cnt    saturating count of stall cycles since reset

module d_branch_ctrl #(
    parameter int unsigned MAX_STALL = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_valid,
    input  logic        D_is_branch,
    input  logic [2:0]  D_CMPop,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic        D_cmp_sig,
    input  logic        D_wr,
    input  logic [4:0]  D_rd,
    input  logic [1:0]  D_lat,
    output logic        D_stall,
    output logic        E_br_valid,
    output logic        E_br_taken,
    output logic        err_timeout,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0][1:0]  sb_q, sb_d;
    logic [15:0]       waitCnt_q, waitCnt_d;
    logic              errTimeout_q, errTimeout_d;
    logic [15:0]       stallCnt_q, stallCnt_d;
    logic              brValid_q, brValid_d;
    logic              brTaken_q, brTaken_d;

    logic isBeq, isBltzal, brValidD, rsBusy, rtBusy, hazard, issue;

    // Decode the branch type; unknown CMPop codes are treated as ordinary
    // instructions, so they never stall and never report a branch.
    always_comb begin
        isBeq    = (D_CMPop == 3'd0);
        isBltzal = (D_CMPop == 3'd1);
        brValidD = D_valid && D_is_branch && (isBeq || isBltzal);
        rsBusy   = (sb_q[D_rs] != 2'd0);
        rtBusy   = (sb_q[D_rt] != 2'd0);
        hazard   = brValidD && (rsBusy || (isBeq && rtBusy));
        D_stall  = hazard;
        issue    = D_valid && !hazard;
    end

    // Scoreboard next state: every pending entry counts down, an issuing
    // writer reloads its destination, and an issuing bltzal reloads $31 for
    // the link write. The link load is applied last so it wins if both hit $31.
    always_comb begin
        sb_d = '0;
        for (int i = 1; i < 32; i++) begin
            sb_d[i] = (sb_q[i] != 2'd0) ? (sb_q[i] - 2'd1) : 2'd0;
        end
        if (issue && D_wr && (D_rd != 5'd0)) begin
            sb_d[D_rd] = D_lat;
        end
        if (issue && brValidD && isBltzal) begin
            sb_d[31] = 2'd1;
        end
        sb_d[0] = 2'd0;
    end

    // FSM next state plus the wait counter and timeout flag. The counter
    // tracks how many consecutive cycles the current branch has spent stalled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hazard)  state_d = WAIT;
            WAIT:    if (!hazard) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (state_d == WAIT) begin
            waitCnt_d = (waitCnt_q == 16'hFFFF) ? waitCnt_q : (waitCnt_q + 16'd1);
        end else begin
            waitCnt_d = 16'd0;
        end

        errTimeout_d = errTimeout_q || ({16'd0, waitCnt_d} > MAX_STALL);
    end

    // Branch report for the E stage and the global stall statistic.
    always_comb begin
        brValid_d  = issue && brValidD;
        brTaken_d  = issue && brValidD && D_cmp_sig;
        stallCnt_d = stallCnt_q;
        if (hazard && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // All state updates; reset discards pending writes and any stall history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            sb_q         <= '0;
            waitCnt_q    <= 16'd0;
            errTimeout_q <= 1'b0;
            stallCnt_q   <= 16'd0;
            brValid_q    <= 1'b0;
            brTaken_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sb_q         <= sb_d;
            waitCnt_q    <= waitCnt_d;
            errTimeout_q <= errTimeout_d;
            stallCnt_q   <= stallCnt_d;
            brValid_q    <= brValid_d;
            brTaken_q    <= brTaken_d;
        end
    end

    assign E_br_valid  = brValid_q;
    assign E_br_taken  = brTaken_q;
    assign err_timeout = errTimeout_q;
    assign stall_cnt   = stallCnt_q;

endmodule

// File: doc/d_branch_ctrl.md
D_BRANCH_CTRL -- requirements
Module: d_branch_ctrl

Interface
REQ-001 Parameter MAX_STALL, default 3, meaning: maximum consecutive stall cycles on one branch before the timeout error is raised.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 D_valid  input  1  an instruction occupies the D stage.
REQ-005 D_is_branch  input  1  the D instruction is a compare-branch (beq or bltzal).
REQ-006 D_CMPop  input  3  branch type: 3'd0 beq (uses rs and rt), 3'd1 bltzal (uses rs only); other codes are not branches.
REQ-007 D_rs, D_rt  input  5 each  source register numbers feeding the D-stage comparator.
REQ-008 D_cmp_sig  input  1  comparator result for the current D operands.
REQ-009 D_wr, D_rd, D_lat  input  1/5/2  the D instruction writes D_rd; its result becomes forwardable to D after D_lat cycles (1 = ALU, 2 = load, 3 = mul).
REQ-010 D_stall  output  1  hold the F and D stages this cycle.
REQ-011 E_br_valid  output  1  a branch left D last cycle (registered).
REQ-012 E_br_taken  output  1  that branch is taken; F redirects (registered).
REQ-013 err_timeout  output  1  sticky: a branch stalled for more than MAX_STALL cycles.
REQ-014 stall_cnt  output  16  saturating count of branch-stall cycles since reset.

Function
REQ-015 The block SHALL hold a scoreboard of 32 two-bit countdown entries; entry 0 SHALL always read 0.
REQ-016 An instruction "issues" in a cycle with D_valid=1 and D_stall=0.
REQ-017 On issue with D_wr=1 and D_rd!=0, entry[D_rd] SHALL load D_lat at the clock edge.
REQ-018 On issue of bltzal (D_is_branch=1, D_CMPop=1), entry[31] SHALL load 1 (link write), whether or not the branch is taken.
REQ-019 Every other nonzero entry SHALL decrement by 1 per cycle; a load into an entry SHALL override its decrement in the same cycle.
REQ-020 The hazard condition SHALL be: D_valid and D_is_branch, and either entry[D_rs]!=0, or D_CMPop=0 with entry[D_rt]!=0; entries are read as held before the edge.
REQ-021 D_stall SHALL equal the hazard condition combinationally; non-branch instructions never stall.
REQ-022 FSM states: RUN and WAIT. RUN->WAIT when the hazard condition holds. WAIT->WAIT while it holds. WAIT->RUN when it clears. Reset enters RUN.
REQ-023 A wait counter SHALL clear in RUN and increment each cycle in WAIT; err_timeout SHALL set when the counter exceeds MAX_STALL, and SHALL stay set until reset.
REQ-024 After the timeout the block SHALL keep stalling and counting normally; the error flag only reports.
REQ-025 A branch issuing at edge N SHALL drive E_br_valid=1 and E_br_taken=D_cmp_sig (sampled at edge N) during cycle N+1.
REQ-026 Otherwise E_br_valid and E_br_taken SHALL be 0.
REQ-027 The block SHALL NOT raise E_br_taken without E_br_valid.
REQ-028 stall_cnt SHALL increment on every cycle with D_stall=1 and SHALL saturate at 16'hFFFF.
REQ-029 Unknown D_CMPop with D_is_branch=1 SHALL be treated as a non-branch: no stall, E_br_valid=0.

Reset
REQ-030 While reset=1 at an edge, all scoreboard entries, the wait counter, E_br_valid, E_br_taken, err_timeout and stall_cnt SHALL clear to 0, and the FSM SHALL enter RUN.
REQ-031 Reset asserted mid-stall SHALL clear the stall on the following cycle; pending writes are discarded.
REQ-032 D_stall SHALL be 0 in the first cycle after reset, with no inputs active.

Verification
REQ-033 ALU write issued to $5 (D_lat=1), then beq $5,$6 next cycle -> D_stall=1 for 1 cycle; branch issues; E_br_valid=1 next cycle; stall_cnt=1.
REQ-034 Load issued to $8 (D_lat=2), then bltzal $8 with D_cmp_sig=1 -> 2 stall cycles; then E_br_taken=1; entry[31]=1, so a following beq $31,$0 stalls 1 cycle.
REQ-035 Back-to-back beq $1,$2 with no pending writes and D_cmp_sig=0,1 -> no stalls; E_br_valid=1,1 and E_br_taken=0,1 on consecutive cycles.
REQ-036 MAX_STALL=1; mul issued to $3 (D_lat=3), then beq $3,$0 -> 3 stall cycles; err_timeout rises when the wait count reaches 2 and stays 1 afterwards.
REQ-037 Write issued to $0 with D_lat=3, then beq $0,$0 -> no stall; E_br_taken follows D_cmp_sig.
REQ-038 Reset pulsed during the second stall cycle of REQ-034 -> next cycle D_stall=0, stall_cnt=0, err_timeout=0.
